// File: rtl/spart_pkg.sv
// Shared SPART definitions: serializer state encoding, default baud divisor, frame length.
// Frame length grows by one bit when SPART_TX_PARITY_EN is defined.
package spart_pkg;

    localparam int SPART_BAUD_DIV_DEFAULT = 434;

    typedef logic [2:0] spart_state_t;

    localparam spart_state_t ST_IDLE   = 3'd0;
    localparam spart_state_t ST_START  = 3'd1;
    localparam spart_state_t ST_DATA   = 3'd2;
    localparam spart_state_t ST_PARITY = 3'd3;
    localparam spart_state_t ST_STOP   = 3'd4;

    localparam int SPART_DATA_BITS = 8;
`ifdef SPART_TX_PARITY_EN
    localparam int SPART_FRAME_BITS = SPART_DATA_BITS + 3;
`else
    localparam int SPART_FRAME_BITS = SPART_DATA_BITS + 2;
`endif

endpackage

// File: rtl/spart_tx_queue_if.sv
// Producer-side bundle of the SPART transmit queue: enqueue request plus occupancy flags.
interface spart_tx_queue_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              send;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (output send, output tx_data, input full, input empty, input count);
    modport slave  (input send, input tx_data, output full, output empty, output count);
endinterface

// File: rtl/spart_tx_fifo.sv
// Circular byte queue with separately tracked occupancy; flags decode straight from the count.
module spart_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          din_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    // A push against a full queue is dropped even if a pop happens the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/spart_tx_queue.sv
// SPART transmit queue plus 8N1 serializer; SPART_TX_PARITY_EN adds an even-parity bit.
// Stop bit of one frame flows straight into the start bit of the next when bytes are waiting.
module spart_tx_queue
    import spart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = SPART_BAUD_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    spart_tx_queue_if.slave  bus,
    output logic             busy,
    output logic             tx
);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    logic [DATA_W-1:0] head;
    logic              pop;
    logic              fifo_empty;

    spart_state_t      state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q;
    logic              bit_end;
`ifdef SPART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    spart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.send),
        .din_i   (bus.tx_data),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (bus.full),
        .empty_o (fifo_empty),
        .count_o (bus.count)
    );
    assign bus.empty = fifo_empty;
    assign bit_end   = (baud_q == '0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef SPART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = BAUD_LOAD;
                    state_d = ST_START;
                    tx_d    = 1'b0;
`ifdef SPART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = BAUD_LOAD;
                    idx_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_LOAD;
                    if (idx_q == IDX_LAST) begin
`ifdef SPART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef SPART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = BAUD_LOAD;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = BAUD_LOAD;
                    // A waiting byte starts immediately so consecutive frames have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = ST_START;
                        tx_d    = 1'b0;
`ifdef SPART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != ST_IDLE);
`ifdef SPART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
endmodule
